sar_adc_seq: RTL and testbench

SAR_ADC_SEQ -- requirements
Module: sar_adc_seq

---
 rtl/sar_adc_pkg.sv | 8 +
 rtl/sar_ch_next.sv | 29 ++
 rtl/sar_adc_seq.sv | 163 ++++++++++++++++
 tb/tb_sar_adc_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared state encoding and default parameters for the SAR ADC sequencer
// Holds no ports; it is imported by sar_ch_next and sar_adc_seq.
package sar_adc_pkg;
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;
    localparam int DEF_RESOLUTION   = 8;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_MAX_AVG_LOG2 = 3;
endpackage

// File: rtl/sar_ch_next.sv
// sar_ch_next: finds the next enabled channel above cur_i, wrapping to the lowest enabled one
// Ports: mask_i channel enables, cur_i current index, nxt_o next index,
//        wrap_o high when no enabled channel lies above cur_i (nxt_o is then the lowest).
module sar_ch_next
    import sar_adc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CW-1:0]     cur_i,
    output logic [CW-1:0]     nxt_o,
    output logic              wrap_o
);
    logic [CW-1:0] lo, hi;
    always_comb begin
        lo     = '0;
        hi     = '0;
        wrap_o = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i]) lo = CW'(i);
            if (mask_i[i] && i > int'(cur_i)) begin
                hi     = CW'(i);
                wrap_o = 1'b0;
            end
        end
        nxt_o = wrap_o ? lo : hi;
    end
endmodule

// File: rtl/sar_adc_seq.sv
// sar_adc_seq: multi-channel SAR ADC sequencer with averaging and a one-deep result register
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/cont_i/ch_en_i/avg_log2_i/
//        sample_cycles_i scan configuration; comp_p_i/comp_n_i comparator; sample_o, ch_sel_o,
//        dac_p_o/dac_n_o analog front-end control; busy_o; valid_o/ready_i/result_o/ch_o result
//        handshake; overrun_o sticky lost-result flag cleared by clr_ovr_i.
module sar_adc_seq
    import sar_adc_pkg::*;
#(
    parameter int RESOLUTION   = DEF_RESOLUTION,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int MAX_AVG_LOG2 = DEF_MAX_AVG_LOG2,
    localparam int CW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int AVW = MAX_AVG_LOG2 > 0 ? $clog2(MAX_AVG_LOG2 + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic [NUM_CH-1:0]     ch_en_i,
    input  logic [AVW-1:0]        avg_log2_i,
    input  logic [3:0]            sample_cycles_i,
    input  logic                  comp_p_i,
    input  logic                  comp_n_i,
    output logic                  sample_o,
    output logic [CW-1:0]         ch_sel_o,
    output logic [RESOLUTION-1:0] dac_p_o,
    output logic [RESOLUTION-1:0] dac_n_o,
    output logic                  busy_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [RESOLUTION-1:0] result_o,
    output logic [CW-1:0]         ch_o,
    output logic                  overrun_o,
    input  logic                  clr_ovr_i
);
    localparam int AW  = RESOLUTION + MAX_AVG_LOG2;
    localparam int NW  = MAX_AVG_LOG2 + 1;
    localparam int BW  = $clog2(RESOLUTION);
    localparam int KW  = BW > 4 ? BW : 4;
    state_t                state_q, state_d;
    logic [KW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         ch_q, ch_d, rch_q, rch_d, nxt_ch, cur_ch;
    logic [NUM_CH-1:0]     en_q, en_d, mask;
    logic [AVW-1:0]        avg_q, avg_d, avg_sat;
    logic [3:0]            smp_q, smp_d;
    logic [RESOLUTION-1:0] dac_p_q, dac_p_d, dac_n_q, dac_n_d, res_q, res_d, bit_m, code;
    logic [AW-1:0]         acc_q, acc_d, acc_sum;
    logic [NW-1:0]         nconv_q, nconv_d;
    logic                  valid_q, valid_d, ovr_q, ovr_d, dec, wrap, last_conv, load;
    // In IDLE the search starts "above" the top index so it returns the lowest enabled channel.
    assign mask   = state_q == IDLE ? ch_en_i : en_q;
    assign cur_ch = state_q == IDLE ? CW'(NUM_CH - 1) : ch_q;
    sar_ch_next #(.NUM_CH(NUM_CH), .CW(CW)) u_next (
        .mask_i(mask),
        .cur_i (cur_ch),
        .nxt_o (nxt_ch),
        .wrap_o(wrap)
    );
    assign dec       = comp_p_i & ~comp_n_i;
    assign bit_m     = {{(RESOLUTION - 1){1'b0}}, 1'b1} << (KW'(RESOLUTION - 1) - cnt_q);
    // dac_p_q already holds every decided 1, so OR-ing in this cycle's decision yields the code.
    assign code      = dac_p_q | (dec ? bit_m : '0);
    assign acc_sum   = (nconv_q == '0 ? '0 : acc_q) + AW'(code);
    assign last_conv = nconv_q == NW'((1 << avg_q) - 1);
    assign avg_sat   = avg_log2_i > AVW'(MAX_AVG_LOG2) ? AVW'(MAX_AVG_LOG2) : avg_log2_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        en_d    = en_q;
        avg_d   = avg_q;
        smp_d   = smp_q;
        dac_p_d = dac_p_q;
        dac_n_d = dac_n_q;
        acc_d   = acc_q;
        nconv_d = nconv_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start_i && |ch_en_i) begin
                state_d = SAMPLE;
                cnt_d   = '0;
                ch_d    = nxt_ch;
                en_d    = ch_en_i;
                avg_d   = avg_sat;
                smp_d   = sample_cycles_i == 4'd0 ? 4'd1 : sample_cycles_i;
                nconv_d = '0;
            end
            SAMPLE: begin
                cnt_d = cnt_q + KW'(1);
                if (cnt_q + KW'(1) == KW'(smp_q)) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                dac_p_d = dac_p_q | (dec ? bit_m : '0);
                dac_n_d = dac_n_q | (dec ? '0 : bit_m);
                cnt_d   = cnt_q + KW'(1);
                if (cnt_q == KW'(RESOLUTION - 1)) begin
                    dac_p_d = '0;
                    dac_n_d = '0;
                    cnt_d   = '0;
                    acc_d   = acc_sum;
                    nconv_d = nconv_q + NW'(1);
                    state_d = SAMPLE;
                    if (last_conv) begin
                        load    = 1'b1;
                        nconv_d = '0;
                        ch_d    = nxt_ch;
                        state_d = wrap && !cont_i ? IDLE : SAMPLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign valid_d = load | (valid_q & ~ready_i);
    assign ovr_d   = (load & valid_q & ~ready_i) | (ovr_q & ~clr_ovr_i);
    assign res_d   = load ? RESOLUTION'(acc_sum >> avg_q) : res_q;
    assign rch_d   = load ? ch_q : rch_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            en_q    <= '0;
            avg_q   <= '0;
            smp_q   <= '0;
            dac_p_q <= '0;
            dac_n_q <= '0;
            acc_q   <= '0;
            nconv_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            res_q   <= '0;
            rch_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            avg_q   <= avg_d;
            smp_q   <= smp_d;
            dac_p_q <= dac_p_d;
            dac_n_q <= dac_n_d;
            acc_q   <= acc_d;
            nconv_q <= nconv_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            res_q   <= res_d;
            rch_q   <= rch_d;
        end
    end
    assign sample_o  = state_q == SAMPLE;
    assign busy_o    = state_q != IDLE;
    assign ch_sel_o  = ch_q;
    assign dac_p_o   = dac_p_q;
    assign dac_n_o   = dac_n_q;
    assign valid_o   = valid_q;
    assign result_o  = res_q;
    assign ch_o      = rch_q;
    assign overrun_o = ovr_q;
endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: directed self-checking bench for sar_adc_seq with a SAR comparator model
module tb_sar_adc_seq;
    logic       clk_i = 1'b0, rst_ni = 1'b1, start_i = 1'b0, cont_i = 1'b0;
    logic [3:0] ch_en_i = '0, sample_cycles_i = '0;
    logic [1:0] avg_log2_i = '0;
    logic       comp_p_i, comp_n_i, ready_i = 1'b0, clr_ovr_i = 1'b0;
    logic       sample_o, busy_o, valid_o, overrun_o;
    logic [1:0] ch_sel_o, ch_o;
    logic [7:0] dac_p_o, dac_n_o, result_o;
    logic [7:0] vin = '0, trial;
    int         nbits;
    int         checks = 0, errors = 0;

    sar_adc_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .cont_i(cont_i),
        .ch_en_i(ch_en_i), .avg_log2_i(avg_log2_i), .sample_cycles_i(sample_cycles_i),
        .comp_p_i(comp_p_i), .comp_n_i(comp_n_i), .sample_o(sample_o), .ch_sel_o(ch_sel_o),
        .dac_p_o(dac_p_o), .dac_n_o(dac_n_o), .busy_o(busy_o), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .ch_o(ch_o), .overrun_o(overrun_o),
        .clr_ovr_i(clr_ovr_i)
    );

    always #5 clk_i = ~clk_i;

    // Comparator: the bit under trial is the next one below those already decided.
    always_comb begin
        nbits = $countones(dac_p_o | dac_n_o);
        trial = dac_p_o | (8'h80 >> nbits);
    end
    assign comp_p_i = vin >= trial;
    assign comp_n_i = ~comp_p_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic go(input logic [3:0] en, input logic [1:0] avg, input logic [3:0] s, input logic c);
        ch_en_i = en;
        avg_log2_i = avg;
        sample_cycles_i = s;
        cont_i = c;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic ack;
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        step(2);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_sample", sample_o, 0);
        chk("rst_dac_p", dac_p_o, 0);
        chk("rst_dac_n", dac_n_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk("rst_ch_sel", ch_sel_o, 0);
        rst_ni = 1'b1;
        step(2);
        chk("idle_after_rst", busy_o, 0);

        // start with no channel enabled is ignored
        start_i = 1'b1;
        step(3);
        chk("noen_busy", busy_o, 0);
        chk("noen_sample", sample_o, 0);
        start_i = 1'b0;

        // single conversion, S=2: valid at cycle 11
        vin = 8'hA5;
        go(4'b0001, 2'd0, 4'd2, 1'b0);
        chk("c1_sample", sample_o, 1);
        chk("c1_busy", busy_o, 1);
        chk("c1_dac_p", dac_p_o, 0);
        step(1);
        chk("c2_sample", sample_o, 1);
        step(1);
        chk("c3_sample", sample_o, 0);
        chk("c3_dac_p", dac_p_o, 0);
        step(1);
        chk("c4_dac_p", dac_p_o, 8'h80);
        chk("c4_dac_n", dac_n_o, 8'h00);
        step(6);
        chk("c10_valid", valid_o, 0);
        chk("c10_dac_p", dac_p_o, 8'hA4);
        chk("c10_dac_n", dac_n_o, 8'h5A);
        step(1);
        chk("c11_valid", valid_o, 1);
        chk("c11_result", result_o, 8'hA5);
        chk("c11_ch", ch_o, 0);
        chk("c11_busy", busy_o, 0);
        chk("c11_dac_p", dac_p_o, 0);
        chk("c11_ovr", overrun_o, 0);
        ack();
        chk("ack_valid", valid_o, 0);

        // two channels 1 and 3, S=0 treated as 1; config changes after start are ignored
        vin = 8'h3C;
        go(4'b1010, 2'd0, 4'd0, 1'b0);
        chk("m_c1_ch_sel", ch_sel_o, 1);
        chk("m_c1_sample", sample_o, 1);
        ch_en_i = 4'hF;
        sample_cycles_i = 4'd9;
        avg_log2_i = 2'd3;
        step(9);
        chk("m_c10_valid", valid_o, 1);
        chk("m_c10_result", result_o, 8'h3C);
        chk("m_c10_ch", ch_o, 1);
        chk("m_c10_ch_sel", ch_sel_o, 3);
        chk("m_c10_sample", sample_o, 1);
        vin = 8'hC3;
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("m_c11_valid", valid_o, 0);
        chk("m_c11_ch_sel", ch_sel_o, 3);
        step(8);
        chk("m_c19_valid", valid_o, 1);
        chk("m_c19_result", result_o, 8'hC3);
        chk("m_c19_ch", ch_o, 3);
        chk("m_c19_busy", busy_o, 0);
        ack();

        // averaging over 4 conversions: 10,11,12,13 -> 46>>2 = 11
        vin = 8'd10;
        go(4'b0001, 2'd2, 4'd2, 1'b0);
        step(10);
        vin = 8'd11;
        step(10);
        vin = 8'd12;
        step(10);
        vin = 8'd13;
        step(9);
        chk("avg_c40_valid", valid_o, 0);
        chk("avg_c40_busy", busy_o, 1);
        step(1);
        chk("avg_c41_valid", valid_o, 1);
        chk("avg_c41_result", result_o, 8'd11);
        chk("avg_c41_busy", busy_o, 0);
        ack();

        // continuous mode, unread results overrun; clear; load with ready keeps valid
        vin = 8'h11;
        go(4'b0001, 2'd0, 4'd1, 1'b1);
        step(9);
        chk("ov_c10_valid", valid_o, 1);
        chk("ov_c10_result", result_o, 8'h11);
        chk("ov_c10_ovr", overrun_o, 0);
        chk("ov_c10_busy", busy_o, 1);
        vin = 8'h22;
        step(9);
        chk("ov_c19_ovr", overrun_o, 1);
        chk("ov_c19_result", result_o, 8'h22);
        chk("ov_c19_valid", valid_o, 1);
        vin = 8'h33;
        cont_i = 1'b0;
        clr_ovr_i = 1'b1;
        step(1);
        clr_ovr_i = 1'b0;
        chk("ov_c20_ovr", overrun_o, 0);
        chk("ov_c20_valid", valid_o, 1);
        step(7);
        chk("ov_c27_result", result_o, 8'h22);
        ready_i = 1'b1;
        step(1);
        chk("ov_c28_valid", valid_o, 1);
        chk("ov_c28_result", result_o, 8'h33);
        chk("ov_c28_ovr", overrun_o, 0);
        chk("ov_c28_busy", busy_o, 0);
        step(1);
        ready_i = 1'b0;
        chk("ov_c29_valid", valid_o, 0);

        // reset in the middle of a conversion (bit 4 being decided)
        vin = 8'hFF;
        go(4'b0001, 2'd0, 4'd2, 1'b0);
        step(5);
        chk("rc_c6_dac_p", dac_p_o, 8'hE0);
        chk("rc_c6_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rc_busy", busy_o, 0);
        chk("rc_dac_p", dac_p_o, 0);
        chk("rc_sample", sample_o, 0);
        chk("rc_valid", valid_o, 0);
        step(2);
        rst_ni = 1'b1;
        step(15);
        chk("rc_post_valid", valid_o, 0);
        chk("rc_post_busy", busy_o, 0);
        chk("rc_post_result", result_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
